// File: rtl/count_pwm_pkg.sv
// Shared types and helpers for the count-driven PWM generator.
// Optional feature macro: PWM_CYCLE_CNT_EN (adds a saturating PWM period counter).
package count_pwm_pkg;

    // Control FSM: IDLE until the first duty arrives, RUN with a settled duty,
    // PENDING while a new duty waits in the shadow register for a period boundary.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } pwm_state_e;

    // Width of the optional completed-period counter.
    localparam int CYCLE_CNT_W = 16;

    // Widest duty value the clamp helper handles (covers counts up to 16 bits).
    localparam int DUTY_MAX_W = CYCLE_CNT_W + 1;

    // Limit a requested duty to the full-period value.
    function automatic logic [DUTY_MAX_W-1:0] clamp_duty(
        input logic [DUTY_MAX_W-1:0] duty,
        input logic [DUTY_MAX_W-1:0] duty_max
    );
        logic [DUTY_MAX_W-1:0] res;
        if (duty > duty_max) begin
            res = duty_max;
        end else begin
            res = duty;
        end
        return res;
    endfunction

endpackage

// File: rtl/count_pwm_gen_wrap_det.sv
// Watches the incoming free-running count and flags period wraps and
// non-sequential jumps relative to the previously sampled value.
module count_wrap_det #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] q_in,
    output logic             wrap,
    output logic             jump
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] q_prev_q;
    logic [CNT_W-1:0] q_prev_d;
    logic [CNT_W-1:0] q_next_s;
    logic             seq_wrap_s;
    logic             zero_jump_s;

    // Classify the current sample against the previous one.
    always_comb begin
        q_prev_d    = q_in;
        q_next_s    = q_prev_q + CNT_ONE;
        seq_wrap_s  = (q_prev_q == CNT_MAX) && (q_in == CNT_ZERO);
        // A jump straight to zero means the counter was reset: treat it as a
        // period boundary rather than a synchronisation error.
        zero_jump_s = (q_in == CNT_ZERO) && (q_prev_q != CNT_ZERO) && !seq_wrap_s;
        wrap        = seq_wrap_s || zero_jump_s;
        // Holding the same value or stepping by one is legal.
        jump        = (q_in != q_prev_q) && (q_in != q_next_s) && (q_in != CNT_ZERO);
    end

    // Remember the last sampled count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_prev_q <= CNT_ZERO;
        end else begin
            q_prev_q <= q_prev_d;
        end
    end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator fed by an external free-running counter. New duty values are
// held in a shadow register and only take effect at a period wrap.
// Optional feature macro: PWM_CYCLE_CNT_EN adds cycle_cnt, a saturating
// count of observed wraps.
module count_pwm_gen
    import count_pwm_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       q_in,
    input  logic                   duty_valid,
    input  logic [CNT_W:0]         duty_in,
    output logic                   duty_ready,
    output logic                   pwm_out,
    output logic                   wrap_pulse,
    output logic                   sync_err
`ifdef PWM_CYCLE_CNT_EN
    ,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt
`endif
);

    localparam int                      DUTY_W    = CNT_W + 1;
    localparam logic [DUTY_W-1:0]       DUTY_ZERO = {DUTY_W{1'b0}};
    localparam logic [DUTY_MAX_W-1:0]   DUTY_FULL = DUTY_MAX_W'(1) << CNT_W;

    pwm_state_e        state_q, state_d;
    logic [DUTY_W-1:0] duty_shadow_q, duty_shadow_d;
    logic [DUTY_W-1:0] duty_active_q, duty_active_d;
    logic              duty_ready_q, duty_ready_d;
    logic              pwm_q, pwm_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              sync_err_q, sync_err_d;

    logic              wrap_s;
    logic              jump_s;
    logic              xfer_s;
    logic              pending_wrap_s;
    logic [DUTY_W-1:0] duty_clamped_s;
    logic [DUTY_W-1:0] eff_duty_s;

    count_wrap_det #(
        .CNT_W (CNT_W)
    ) u_wrap_det (
        .clk  (clk),
        .rst  (rst),
        .q_in (q_in),
        .wrap (wrap_s),
        .jump (jump_s)
    );

    // Next-state logic: handshake, shadow/active duty update and compare.
    always_comb begin
        state_d        = state_q;
        duty_shadow_d  = duty_shadow_q;
        duty_active_d  = duty_active_q;

        xfer_s         = duty_valid && duty_ready_q;
        duty_clamped_s = DUTY_W'(clamp_duty(DUTY_MAX_W'(duty_in), DUTY_FULL));
        pending_wrap_s = (state_q == PENDING) && wrap_s;

        // On the wrap that commits a pending duty, the new value already
        // governs sample 0 of the new period.
        if (pending_wrap_s) begin
            eff_duty_s = duty_shadow_q;
        end else begin
            eff_duty_s = duty_active_q;
        end

        case (state_q)
            IDLE, RUN: begin
                // A transfer coinciding with a wrap is still only staged;
                // it is committed at the following wrap.
                if (xfer_s) begin
                    state_d       = PENDING;
                    duty_shadow_d = duty_clamped_s;
                end else begin
                    state_d       = state_q;
                end
            end
            PENDING: begin
                if (wrap_s) begin
                    state_d       = RUN;
                    duty_active_d = duty_shadow_q;
                end else begin
                    state_d       = PENDING;
                end
            end
            default: begin
                state_d       = IDLE;
                duty_shadow_d = DUTY_ZERO;
                duty_active_d = DUTY_ZERO;
            end
        endcase

        pwm_d        = (state_q != IDLE) && ({1'b0, q_in} < eff_duty_s);
        duty_ready_d = (state_d != PENDING);
        wrap_pulse_d = wrap_s;
        sync_err_d   = jump_s;
    end

    // FSM, duty registers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            duty_shadow_q <= DUTY_ZERO;
            duty_active_q <= DUTY_ZERO;
            duty_ready_q  <= 1'b1;
            pwm_q         <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            duty_ready_q  <= duty_ready_d;
            pwm_q         <= pwm_d;
            wrap_pulse_q  <= wrap_pulse_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign duty_ready = duty_ready_q;
    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_pulse_q;
    assign sync_err   = sync_err_q;

`ifdef PWM_CYCLE_CNT_EN
    localparam logic [CYCLE_CNT_W-1:0] CYC_MAX = {CYCLE_CNT_W{1'b1}};
    localparam logic [CYCLE_CNT_W-1:0] CYC_ONE = {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};

    logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    // Count wrap pulses, holding at the maximum instead of rolling over.
    always_comb begin
        if (wrap_pulse_q && (cycle_cnt_q != CYC_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + CYC_ONE;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= {CYCLE_CNT_W{1'b0}};
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Bench for count_pwm_gen (CNT_W=4): directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the PWM rules.
module tb_count_pwm_gen;

    localparam int PERIOD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] q_in = 4'd0;
    logic       duty_valid = 1'b0;
    logic [4:0] duty_in = 5'd0;
    logic       duty_ready;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       sync_err;
`ifdef PWM_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_active;
    int m_prev;
    int m_queue[$];
    bit m_enabled;
    bit e_pwm;
    bit e_wrap;
    bit e_sync;
    int e_cyc;
    int cnt;

    always #5 clk = ~clk;

    count_pwm_gen #(
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .duty_valid (duty_valid),
        .duty_in    (duty_in),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .sync_err   (sync_err)
`ifdef PWM_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_prev    = 0;
        m_queue.delete();
        m_enabled = 1'b0;
        e_pwm     = 1'b0;
        e_wrap    = 1'b0;
        e_sync    = 1'b0;
        e_cyc     = 0;
    endtask

    task automatic check_outputs(input string sfx);
        check({"pwm_out", sfx}, pwm_out, e_pwm);
        check({"wrap_pulse", sfx}, wrap_pulse, e_wrap);
        check({"sync_err", sfx}, sync_err, e_sync);
`ifdef PWM_CYCLE_CNT_EN
        check({"cycle_cnt", sfx}, cycle_cnt, e_cyc);
`endif
    endtask

    // One clock: drive a sample, predict, then compare after the edge.
    task automatic step(input int q, input bit v, input int d);
        bit is_wrap;
        bit ready;
        int eff;
        @(negedge clk);
        q_in       = 4'(q);
        duty_valid = v;
        duty_in    = 5'(d);
        ready      = (m_queue.size() == 0);
        #1;
        check("duty_ready", duty_ready, ready);

        is_wrap = (q == 0) && (m_prev != 0);
        eff     = (is_wrap && m_queue.size() > 0) ? m_queue[0] : m_active;
        if (e_wrap && e_cyc < 65535) e_cyc++;
        e_pwm  = m_enabled && (q < eff);
        e_wrap = is_wrap;
        e_sync = (q != m_prev) && (q != (m_prev + 1) % PERIOD) && (q != 0);
        if (is_wrap && m_queue.size() > 0) m_active = m_queue.pop_front();
        if (v && ready) begin
            m_queue.push_back((d > PERIOD) ? PERIOD : d);
            m_enabled = 1'b1;
        end
        m_prev = q;

        @(posedge clk);
        #1;
        check_outputs("");
        duty_valid = 1'b0;
    endtask

    task automatic tick(input bit v, input int d);
        step(cnt, v, d);
        cnt = (cnt + 1) % PERIOD;
    endtask

    // Offer a duty when the block is ready, then run to the next period start.
    task automatic load(input int d);
        for (int i = 0; i < 3 * PERIOD && m_queue.size() != 0; i++) tick(1'b0, 0);
        check("load_ready", duty_ready, 1);
        tick(1'b1, d);
        for (int i = 0; i < PERIOD && cnt != 0; i++) tick(1'b0, 0);
    endtask

    // Run one full period from q=0 and count high output samples.
    task automatic period_count(input bit v0, input int d0, input int exp_high, input string tag);
        int highs;
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick((i == 0) ? v0 : 1'b0, d0);
            highs += int'(pwm_out);
        end
        check(tag, highs, exp_high);
    endtask

    initial begin
        int rj;
        int rv;
        int rd;
        model_reset();
        cnt = 0;

        // 1: reset held, then IDLE with no load.
        repeat (3) @(posedge clk);
        #1;
        check_outputs("_rst");
        check("duty_ready_rst", duty_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick(1'b0, 0);

        // 2: duty 4 loaded mid-period.
        load(4);
        period_count(1'b0, 0, 4, "duty4_p1");
        period_count(1'b0, 0, 4, "duty4_p2");

        // 3: duty extremes and clamping.
        load(0);
        period_count(1'b0, 0, 0, "duty0");
        load(16);
        period_count(1'b0, 0, 16, "duty16");
        load(20);
        period_count(1'b0, 0, 16, "duty20_clamped");

        // 4: load on the exact wrap cycle while running.
        period_count(1'b1, 8, 16, "xfer_on_wrap_old");
        period_count(1'b0, 0, 8, "xfer_on_wrap_new");

        // 5: out-of-sequence jump, then a jump to zero.
        while (cnt != 5) tick(1'b0, 0);
        tick(1'b0, 0);
        step(9, 1'b0, 0);
        check("sync_err_jump", sync_err, 1);
        cnt = 10;
        while (cnt != 8) tick(1'b0, 0);
        step(0, 1'b0, 0);
        check("zero_jump_wrap", wrap_pulse, 1);
        check("zero_jump_noerr", sync_err, 0);
        cnt = 1;
        tick(1'b0, 0);
        step(1, 1'b0, 0);
        check("held_noerr", sync_err, 0);
        cnt = 2;

        // 6: reset while a duty is pending, at q_in=10.
        tick(1'b1, 12);
        while (cnt != 11) tick(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("_async_rst");
        check("duty_ready_async_rst", duty_ready, 1);
        q_in = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (3 * PERIOD + 2) tick(1'b0, 0);

        // Random phase: random loads, duties and occasional count jumps.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 5) == 0) ? 1 : 0;
            rd = int'($urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) begin
                rj = int'($urandom_range(0, 15));
                step(rj, rv[0], rd);
                cnt = (rj + 1) % PERIOD;
            end else begin
                tick(rv[0], rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
